// File: rtl/coin_pkg.sv
// Shared constants for the coin front end and the vending controller that consumes its pulses.
package coin_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int JAM_CYCLES_DEF      = 64;

   typedef logic [1:0] coin_t;

   localparam coin_t COIN_NONE = 2'd0;
   localparam coin_t COIN_5    = 2'd1;
   localparam coin_t COIN_10   = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_PEND5 = 2'd1,
      ST_JAM   = 2'd2
   } acc_state_e;

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: two-flop synchronizer, debounce filter, rising-edge detect
// and a saturating stuck-high timer.
module coin_debounce
   import coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int JAM_CYCLES      = JAM_CYCLES_DEF,
   parameter int CNT_W           = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic rise,
   output logic stable,
   output logic stuck
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] JAM_TC  = CNT_W'(JAM_CYCLES);

   logic             sync1;
   logic             sync2;
   logic             stable_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hi_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= '0;
         hi_cnt   <= '0;
      end else begin
         sync1    <= raw;
         sync2    <= sync1;
         stable_d <= stable;

         // any sample matching the stable level restarts the qualification window
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end

         if (!stable) begin
            hi_cnt <= '0;
         end else if (hi_cnt != JAM_TC) begin
            hi_cnt <= hi_cnt + 1'b1;
         end
      end
   end

   assign rise  = stable & ~stable_d;
   assign stuck = (hi_cnt == JAM_TC);

endmodule

// File: rtl/coin_acceptor.sv
// Coin slot front end: turns two bouncy sensors into single-cycle in5/in10 pulses,
// with reject when disabled and jam suppression.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal acceptance, rises map straight to in5/in10/reject
//   ST_PEND5 | in10 just issued for a simultaneous pair, in5 owed now
//   ST_JAM   | a sensor is stuck high, all pulses suppressed
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int JAM_CYCLES      = JAM_CYCLES_DEF,
   parameter int CNT_W           = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic coin5_raw,
   input  logic coin10_raw,
   input  logic enable,
   output logic in5,
   output logic in10,
   output logic reject,
   output logic jam
);

   logic       rise5, rise10;
   logic       stable5, stable10;
   logic       stuck5, stuck10;
   acc_state_e state, state_n;
   coin_t      grant;
   logic       rej_nxt;

   coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .JAM_CYCLES     (JAM_CYCLES),
      .CNT_W          (CNT_W)
   ) u_deb5 (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (coin5_raw),
      .rise   (rise5),
      .stable (stable5),
      .stuck  (stuck5)
   );

   coin_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .JAM_CYCLES     (JAM_CYCLES),
      .CNT_W          (CNT_W)
   ) u_deb10 (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (coin10_raw),
      .rise   (rise10),
      .stable (stable10),
      .stuck  (stuck10)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_RUN;
         in5    <= 1'b0;
         in10   <= 1'b0;
         reject <= 1'b0;
      end else begin
         state  <= state_n;
         in5    <= (grant == COIN_5);
         in10   <= (grant == COIN_10);
         reject <= rej_nxt;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_JAM:   if (!stable5 && !stable10) state_n = ST_RUN;
         ST_PEND5: state_n = ST_RUN;
         default:  state_n = (rise5 && rise10 && enable) ? ST_PEND5 : ST_RUN;
      endcase
      // a stuck sensor overrides everything, dropping any owed in5
      if (stuck5 || stuck10) state_n = ST_JAM;
   end

   always_comb begin
      grant   = COIN_NONE;
      rej_nxt = 1'b0;
      case (state)
         ST_RUN: begin
            if (rise5 || rise10) begin
               if (!enable)     rej_nxt = 1'b1;
               else if (rise10) grant   = COIN_10;
               else             grant   = COIN_5;
            end
         end
         ST_PEND5: if (enable) grant = COIN_5;
         default:  ;
      endcase
   end

   assign jam = (state == ST_JAM);

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random sensor traffic, all
// outputs compared every cycle against a window/queue reference model.
module tb_coin_acceptor;

   localparam int D   = 4;
   localparam int JAM = 64;

   logic clk = 1'b0;
   logic reset_n, coin5_raw, coin10_raw, enable;
   logic in5, in10, reject, jam;

   int n_chk = 0, n_fail = 0;
   int cyc = 0;
   int n5 = 0, n10 = 0, nrej = 0;
   int last5 = -1, last10 = -1, lastrej = -1, jam_rise = -1;
   logic prev_jam = 1'b0;

   // reference model state
   logic [D:0] h5 = '0, h10 = '0;
   logic m_st5 = 1'b0, m_st10 = 1'b0, m_ev5 = 1'b0, m_ev10 = 1'b0, m_jam = 1'b0;
   logic m_in5 = 1'b0, m_in10 = 1'b0, m_rej = 1'b0;
   int   m_hi5 = 0, m_hi10 = 0;
   int   mq[$];

   always #5 clk = ~clk;

   coin_acceptor #(
      .DEBOUNCE_CYCLES(D),
      .JAM_CYCLES     (JAM),
      .CNT_W          (8)
   ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .coin5_raw (coin5_raw),
      .coin10_raw(coin10_raw),
      .enable    (enable),
      .in5       (in5),
      .in10      (in10),
      .reject    (reject),
      .jam       (jam)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      h5 = '0; h10 = '0;
      m_st5 = 1'b0; m_st10 = 1'b0; m_ev5 = 1'b0; m_ev10 = 1'b0; m_jam = 1'b0;
      m_in5 = 1'b0; m_in10 = 1'b0; m_rej = 1'b0;
      m_hi5 = 0; m_hi10 = 0;
      mq.delete();
   endtask

   // One clock edge: coins seen last edge are queued (10 before 5) and issued one per
   // cycle; a level is accepted once the last D synchronized samples all disagree with it.
   task automatic model_edge();
      int   c;
      logic f5, f10;
      m_in5 = 1'b0; m_in10 = 1'b0; m_rej = 1'b0;
      if (m_jam) begin
         mq.delete();
      end else begin
         if (m_ev10 || m_ev5) begin
            if (!enable) m_rej = 1'b1;
            else begin
               if (m_ev10) mq.push_back(10);
               if (m_ev5)  mq.push_back(5);
            end
         end
         if (mq.size() > 0) begin
            c = mq.pop_front();
            if (enable) begin
               if (c == 10) m_in10 = 1'b1;
               else         m_in5  = 1'b1;
            end
         end
      end
      if (m_hi5 >= JAM || m_hi10 >= JAM) m_jam = 1'b1;
      else if (!m_st5 && !m_st10)       m_jam = 1'b0;
      m_hi5  = m_st5  ? ((m_hi5  < JAM) ? m_hi5  + 1 : JAM) : 0;
      m_hi10 = m_st10 ? ((m_hi10 < JAM) ? m_hi10 + 1 : JAM) : 0;
      f5  = m_st5  ? (h5[D:1]  == '0) : (&h5[D:1]);
      f10 = m_st10 ? (h10[D:1] == '0) : (&h10[D:1]);
      m_ev5  = f5  && !m_st5;
      m_ev10 = f10 && !m_st10;
      if (f5)  m_st5  = !m_st5;
      if (f10) m_st10 = !m_st10;
      h5  = {h5[D-1:0],  coin5_raw};
      h10 = {h10[D-1:0], coin10_raw};
   endtask

   initial begin
      #12;
      forever begin
         @(posedge clk or negedge reset_n);
         if (clk) cyc++;
         if (!reset_n) model_reset();
         else          model_edge();
         #1;
         chk("in5",    32'(in5),        32'(m_in5));
         chk("in10",   32'(in10),       32'(m_in10));
         chk("reject", 32'(reject),     32'(m_rej));
         chk("jam",    32'(jam),        32'(m_jam));
         chk("excl",   32'(in5 & in10), 0);
         if (in5)    begin n5++;   last5   = cyc; end
         if (in10)   begin n10++;  last10  = cyc; end
         if (reject) begin nrej++; lastrej = cyc; end
         if (jam && !prev_jam) jam_rise = cyc;
         prev_jam = jam;
      end
   end

   initial begin
      int t0, s5, s10, sr;
      int len5, len10;
      reset_n = 1'b0; coin5_raw = 1'b0; coin10_raw = 1'b0; enable = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in5",     32'(in5),    0);
      chk("rst_in10",    32'(in10),   0);
      chk("rst_reject",  32'(reject), 0);
      chk("rst_jam",     32'(jam),    0);
      chk("rst_stable5", 32'(u_dut.u_deb5.stable), 0);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_rst_quiet", n5 + n10 + nrej, 0);

      // clean coin5
      s5 = n5; s10 = n10; sr = nrej;
      t0 = cyc + 1; coin5_raw = 1'b1;
      repeat (10) @(negedge clk);
      coin5_raw = 1'b0;
      repeat (20) @(negedge clk);
      chk("clean_n5",  n5 - s5, 1);
      chk("clean_lat", last5 - t0, D + 2);
      chk("clean_n10", n10 - s10, 0);
      chk("clean_rej", nrej - sr, 0);

      // bouncing coin10
      s10 = n10;
      coin10_raw = 1'b1; @(negedge clk);
      coin10_raw = 1'b0; @(negedge clk);
      coin10_raw = 1'b1; @(negedge clk);
      coin10_raw = 1'b0; @(negedge clk);
      t0 = cyc + 1; coin10_raw = 1'b1;
      repeat (12) @(negedge clk);
      coin10_raw = 1'b0;
      repeat (20) @(negedge clk);
      chk("bounce_n10", n10 - s10, 1);
      chk("bounce_lat", last10 - t0, D + 2);

      // glitch of D-1 cycles is filtered
      s5 = n5;
      coin5_raw = 1'b1;
      repeat (D - 1) @(negedge clk);
      coin5_raw = 1'b0;
      repeat (12) begin
         @(negedge clk);
         chk("glitch_stable", 32'(u_dut.u_deb5.stable), 0);
      end
      chk("glitch_n5", n5 - s5, 0);

      // exactly D cycles high is accepted
      s5 = n5;
      coin5_raw = 1'b1;
      repeat (D) @(negedge clk);
      coin5_raw = 1'b0;
      repeat (20) @(negedge clk);
      chk("min_width_n5", n5 - s5, 1);

      // simultaneous coins
      s5 = n5; s10 = n10;
      t0 = cyc + 1; coin5_raw = 1'b1; coin10_raw = 1'b1;
      repeat (10) @(negedge clk);
      coin5_raw = 1'b0; coin10_raw = 1'b0;
      repeat (20) @(negedge clk);
      chk("simul_n10", n10 - s10, 1);
      chk("simul_n5",  n5 - s5, 1);
      chk("simul_lat10", last10 - t0, D + 2);
      chk("simul_lat5",  last5 - t0, D + 3);

      // disabled coin5, then disabled pair
      enable = 1'b0;
      s5 = n5; sr = nrej;
      t0 = cyc + 1; coin5_raw = 1'b1;
      repeat (10) @(negedge clk);
      coin5_raw = 1'b0;
      repeat (20) @(negedge clk);
      chk("dis_rej", nrej - sr, 1);
      chk("dis_rej_lat", lastrej - t0, D + 2);
      chk("dis_n5", n5 - s5, 0);
      s5 = n5; s10 = n10; sr = nrej;
      coin5_raw = 1'b1; coin10_raw = 1'b1;
      repeat (10) @(negedge clk);
      coin5_raw = 1'b0; coin10_raw = 1'b0;
      repeat (20) @(negedge clk);
      chk("dis_pair_rej", nrej - sr, 1);
      chk("dis_pair_coins", (n5 - s5) + (n10 - s10), 0);
      enable = 1'b1;
      s10 = n10; sr = nrej;
      coin10_raw = 1'b1;
      repeat (10) @(negedge clk);
      coin10_raw = 1'b0;
      repeat (20) @(negedge clk);
      chk("reen_n10", n10 - s10, 1);
      chk("reen_rej", nrej - sr, 0);

      // jam on coin10, coin5 inserted during jam
      s5 = n5; s10 = n10; sr = nrej;
      t0 = cyc + 1; coin10_raw = 1'b1;
      repeat (80) @(negedge clk);
      coin5_raw = 1'b1;
      repeat (10) @(negedge clk);
      coin5_raw = 1'b0;
      repeat (10) @(negedge clk);
      chk("jam_mid", 32'(jam), 1);
      coin10_raw = 1'b0;
      repeat (20) @(negedge clk);
      chk("jam_n10", n10 - s10, 1);
      chk("jam_n5",  n5 - s5, 0);
      chk("jam_rej", nrej - sr, 0);
      chk("jam_lat", jam_rise - t0, D + JAM + 2);
      chk("jam_clear", 32'(jam), 0);

      // reset mid-debounce loses the coin
      s5 = n5;
      coin5_raw = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b0; coin5_raw = 1'b0;
      #1;
      chk("mid_rst_in5",    32'(in5),    0);
      chk("mid_rst_reject", 32'(reject), 0);
      chk("mid_rst_jam",    32'(jam),    0);
      chk("mid_rst_stable", 32'(u_dut.u_deb5.stable), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_rst_n5", n5 - s5, 0);

      // reset released with the sensor held high gives one fresh coin
      s5 = n5;
      reset_n = 1'b0; coin5_raw = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1; t0 = cyc + 1;
      repeat (15) @(negedge clk);
      chk("held_rst_n5",  n5 - s5, 1);
      chk("held_rst_lat", last5 - t0, D + 2);
      coin5_raw = 1'b0;
      repeat (15) @(negedge clk);

      // random traffic: bounces, valid coins, occasional jams, enable flips, short resets
      len5 = 0; len10 = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (len5 == 0) begin
            coin5_raw = ~coin5_raw;
            len5 = ($urandom_range(0, 29) == 0) ? int'($urandom_range(66, 90)) : int'($urandom_range(1, 12));
         end else len5--;
         if (len10 == 0) begin
            coin10_raw = ~coin10_raw;
            len10 = ($urandom_range(0, 29) == 0) ? int'($urandom_range(66, 90)) : int'($urandom_range(1, 12));
         end else len10--;
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         reset_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      end
      reset_n = 1'b1; coin5_raw = 1'b0; coin10_raw = 1'b0; enable = 1'b1;
      repeat (30) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage directly upstream of the vending controller.
- Takes raw, asynchronous, bouncy coin-slot sensor levels for 5- and 10-unit coins.
- Converts each physical coin into exactly one single-cycle in5/in10 pulse, synchronous to clk, for the controller to consume.
- Also detects jammed sensors and suppresses coin pulses while a jam persists.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized level must differ from the stable level before it is accepted. Minimum 2.
- JAM_CYCLES, 64: consecutive cycles a stable level may stay high before the channel is declared jammed. Must exceed DEBOUNCE_CYCLES.
- CNT_W, 8: width of the debounce and jam counters. Must hold JAM_CYCLES.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- coin5_raw  input  1  raw 5-unit slot sensor, asynchronous, may bounce.
- coin10_raw  input  1  raw 10-unit slot sensor, asynchronous, may bounce.
- enable  input  1  coin acceptance enable from the controller side.
- in5  output  1  one-cycle pulse: one 5-unit coin accepted.
- in10  output  1  one-cycle pulse: one 10-unit coin accepted.
- reject  output  1  one-cycle pulse: a coin was detected while enable=0.
- jam  output  1  level: a sensor is stuck high.

Interface (already decided): one clock, clk. Reset reset_n is asynchronous and active-low.

Behaviour:
- Reset:
  - All flops clear: synchronizers, stable levels, counters, pending flag.
  - in5=0, in10=0, reject=0, jam=0.
  - Deassertion of reset_n is consumed synchronously; no pulse is generated on the first edges after reset.
- Synchronizer: two flops per channel (sync1, sync2).
- Debounce, per channel:
  - While sync2 != stable, cnt increments each edge.
  - On the edge where cnt==DEBOUNCE_CYCLES-1 and sync2 still differs, stable <= sync2 and cnt <= 0.
  - If sync2 == stable, cnt <= 0. Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Edge detect: rise = stable & ~stable_d, one cycle per accepted coin. Falling edges produce nothing.
- Latency: raw first sampled high at edge N (held stable) -> output pulse high from edge N+DEBOUNCE_CYCLES+2 for exactly one cycle. With default D=4, that is N+6.
- Output registering: in5, in10 and reject are registered outputs.
- Priority and simultaneity:
  - If rise5 and rise10 occur in the same cycle: in10 pulses first; pending5 is set and in5 pulses on the next cycle.
  - in5 and in10 are never high in the same cycle.
  - A pending5 is always drained before any new rise5 can occur, because DEBOUNCE_CYCLES>=2.
- Enable:
  - A rise while enable=0 produces reject (one cycle) instead of in5/in10.
  - Simultaneous rises while disabled produce a single reject pulse.
  - enable is sampled in the same cycle as the rise; a pending5 is also dropped if enable=0 when it drains.
- Jam, per channel:
  - hi_cnt counts consecutive cycles with stable=1 and saturates at JAM_CYCLES.
  - When either hi_cnt reaches JAM_CYCLES, jam <= 1.
  - jam is sticky until both stable levels are 0, then clears on the next edge.
  - While jam=1: in5, in10 and reject are forced to 0 and pending5 is cleared.
  - A rise on the other channel during a jam is discarded, not queued.
- Reset mid-operation: asynchronous clear of all state. A coin partially debounced is lost, and no pulse is emitted after reset release unless a fresh low-to-high is seen.
- Reset while raw is held high: stable returns to 1 after debounce. A stable level coming out of reset counts as a rise and emits one pulse — that is the required behaviour; the bench must verify it.

Decomposition:
- Shared package coin_pkg:
  - Default constants DEBOUNCE_CYCLES_DEF, JAM_CYCLES_DEF.
  - Coin code constants COIN_NONE, COIN_5, COIN_10, shared with the vending controller.
- Sub-module coin_debounce, instantiated twice:
  - Contains the two-flop synchronizer, debounce counter, stable level, rise output and saturating hi_cnt.
  - Outputs: rise, stable, stuck.
- Top level: priority/pending logic, enable/reject and jam logic.

Test Plan (D=4, JAM=64 unless stated):
- Clean coin: coin5_raw high 10 cycles from edge 20 -> in5 high exactly in cycle 26, in10/reject stay 0.
- Bounce: coin10_raw toggles 1,0,1,0 every cycle, then held high from edge 40 -> exactly one in10 pulse at edge 46, none earlier.
- Glitch: coin5_raw high for 3 cycles only -> no in5 pulse, stable stays 0.
- Simultaneous: both raws rise at edge 50 -> in10 at 56, in5 at 57, never overlapping.
- Disabled: enable=0, coin5 inserted at edge 70 -> reject at 76, in5 stays 0. Then enable=1 and a coin10 -> in10 only.
- Jam and reset: coin10_raw held high 100 cycles -> in10 once, jam=1 from 64 cycles after stable rise; a coin5 during jam gives no pulse; release -> jam clears. Then assert reset_n=0 mid-debounce of a coin5 -> all outputs 0 and no pulse after release.
